apb_mem_slave: RTL

APB completer holding a word-addressed SRAM window, placed directly downstream of the AXI-to-APB bridge on one `psel` bit. A 4 KB window matches one bridge slave region, e.g. 0x0001_F000–0x0001_FFFF. It inserts a programmable number of wait states and returns `pslverr` for:

- out-of-window accesses;
- unaligned accesses;
- writes to its read-only ID word.

It serves as both the real SLV1/SLV2 endpoint and the bench model for the bridge.

---
 rtl/apb_mem_pkg.sv | 42 ++++
 rtl/sp_sram.sv | 30 +++
 rtl/apb_mem_slave.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and decode helpers for the APB SRAM-window completer.
// Addresses are widened to 64 bits so window arithmetic cannot overflow.
package apb_mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned WAIT_CNT_WIDTH = 4;

    // Byte offset of the read-only ID word: the last word of the window.
    function automatic logic [63:0] id_offset(input int unsigned depth_lg2);
        return ((64'd1 << depth_lg2) - 64'd1) << 2;
    endfunction

    function automatic logic is_id_word(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned depth_lg2
    );
        return (addr >= base) && ((addr - base) == id_offset(depth_lg2));
    endfunction

    function automatic logic addr_error(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned depth_lg2,
        input logic        write
    );
        logic [63:0] win_bytes;
        logic        unaligned;
        logic        outside;
        logic        id_write;
        win_bytes = 64'd1 << (depth_lg2 + 2);
        unaligned = (addr[1:0] != 2'b00);
        outside   = (addr < base) || (addr >= base + win_bytes);
        id_write  = write && is_id_word(addr, base, depth_lg2);
        return unaligned || outside || id_write;
    endfunction

endpackage

// File: rtl/sp_sram.sv
// Single-port 1RW synchronous SRAM, one-cycle read latency, no reset.
// Kept behaviourally simple so it can be replaced by a foundry macro.
module sp_sram #(
    parameter int unsigned DEPTH_LG2  = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LG2-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LG2];

    // NOTE: the array and read register are deliberately left unreset; a
    // reset would prevent mapping onto a RAM macro, and rdata holds its last
    // value while en is low.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer exposing a word-addressed SRAM window with programmable wait
// states, a read-only ID word in the last slot, and pslverr on bad accesses.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0001_F000,
    parameter int unsigned           DEPTH_LG2   = 10,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    localparam logic [63:0]               BASE64    = 64'(BASE_ADDR);
    localparam logic [63:0]               WIN_MASK  = (64'd1 << (DEPTH_LG2 + 2)) - 64'd1;
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);
    localparam logic                      NO_WAIT   = (WAIT_CYCLES == 0);

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_mem_slave: WAIT_CYCLES must be in 0..15");
    end
    if ((BASE64 & WIN_MASK) != 64'd0) begin : g_bad_base
        $error("apb_mem_slave: BASE_ADDR must be aligned to the window size");
    end

    state_t                    state;
    logic [WAIT_CNT_WIDTH-1:0] cnt;
    logic                      write_r;
    logic                      err_r;
    logic                      id_r;
    logic [DEPTH_LG2-1:0]      idx_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic                      pready_r;
    logic                      pslverr_r;
    logic                      rd_ok_r;

    logic                      setup;
    logic                      setup_err;
    logic                      setup_id;
    logic [DEPTH_LG2-1:0]      setup_idx;

    logic                      sram_en;
    logic                      sram_we;
    logic [DEPTH_LG2-1:0]      sram_addr;
    logic [DATA_WIDTH-1:0]     sram_rdata;

    assign setup     = (state == IDLE) && psel_i && !penable_i;
    assign setup_err = addr_error(64'(paddr_i), BASE64, DEPTH_LG2, pwrite_i);
    assign setup_id  = is_id_word(64'(paddr_i), BASE64, DEPTH_LG2);
    assign setup_idx = paddr_i[DEPTH_LG2+1:2];

    // Writes commit only at the completion edge, and only while still selected.
    assign sram_we   = (state == ACCESS) && psel_i && pready_r && write_r && !err_r;
    assign sram_en   = (setup && !pwrite_i && !setup_err && !setup_id) || sram_we;
    assign sram_addr = (state == IDLE) ? setup_idx : idx_r;

    sp_sram #(
        .DEPTH_LG2 (DEPTH_LG2),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sram (
        .clk  (clk),
        .en   (sram_en),
        .we   (sram_we),
        .addr (sram_addr),
        .wdata(wdata_r),
        .rdata(sram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            write_r   <= 1'b0;
            err_r     <= 1'b0;
            id_r      <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            rd_ok_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state     <= ACCESS;
                        write_r   <= pwrite_i;
                        err_r     <= setup_err;
                        id_r      <= setup_id;
                        idx_r     <= setup_idx;
                        wdata_r   <= pwdata_i;
                        cnt       <= WAIT_LOAD;
                        pready_r  <= NO_WAIT;
                        pslverr_r <= NO_WAIT && setup_err;
                        rd_ok_r   <= NO_WAIT && !pwrite_i && !setup_err;
                    end
                end
                ACCESS: begin
                    if (!psel_i || pready_r) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                        rd_ok_r   <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        // Last wait cycle: raise pready so it is registered for completion.
                        if (cnt == WAIT_CNT_WIDTH'(1)) begin
                            pready_r  <= 1'b1;
                            pslverr_r <= err_r;
                            rd_ok_r   <= !write_r && !err_r;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM data is read at the setup edge and held (en low) until completion;
    // prdata is a register-sourced mux, so no input reaches it combinationally.
    assign prdata_o  = rd_ok_r ? (id_r ? ID_VALUE : sram_rdata) : '0;
    assign pready_o  = pready_r;
    assign pslverr_o = pslverr_r;

endmodule
